// File: rtl/matrix_stream_loader_if.sv
// Bus bundle for the matrix stream loader: configuration request, element
// stream, packed matrix output and the start/done handshake to the consumer.
//
// Handshakes: an element transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready never depends on in_valid. A frame request
// is taken on an edge where cfg_valid is high while the loader is idle (busy=0).
// The consumer sees start held high until it raises done; start drops after
// done is sampled, and the loader waits for done to fall before going idle.
interface matrix_stream_loader_if;
  logic          cfg_valid;
  logic [2:0]    rows;
  logic [2:0]    cols;
  logic          cfg_err;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic [1151:0] Aout;
  logic          start;
  logic          done;
  logic          busy;
  logic [1:0]    dbg_state;

  modport master (
    output cfg_valid, rows, cols, in_valid, in_data, done,
    input  cfg_err, in_ready, Aout, start, busy, dbg_state
  );

  modport slave (
    input  cfg_valid, rows, cols, in_valid, in_data, done,
    output cfg_err, in_ready, Aout, start, busy, dbg_state
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Serial-to-packed matrix loader: collects up to 6x6 signed Q20.12 elements
// in row-major order into a zero-padded 1152-bit bus, then holds that bus
// stable across a start/done handshake with the downstream matrix block.
module matrix_stream_loader (
  input  logic                  clk,
  input  logic                  rst,
  matrix_stream_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [5:0]    total_q, total_d;
  logic [1151:0] aout_q, aout_d;
  logic          start_q, start_d;
  logic          cfg_err_q, cfg_err_d;
  logic          dims_ok;

  // Legal dimensions are 1..6; both 0 and 7 are rejected.
  assign dims_ok = (bus.rows != 3'd0) && (bus.rows != 3'd7) &&
                   (bus.cols != 3'd0) && (bus.cols != 3'd7);

  // Next-state and datapath updates; every target defaults to holding.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    total_d   = total_q;
    aout_d    = aout_q;
    start_d   = start_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid) begin
          if (dims_ok) begin
            // Only the element count is needed afterwards: slot index is the
            // running accept count, which is already i*cols+j in row-major order.
            total_d = 6'(bus.rows) * 6'(bus.cols);
            aout_d  = '0;
            idx_d   = 6'd0;
            state_d = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          aout_d[{idx_q, 5'd0} +: 32] = bus.in_data;
          idx_d = idx_q + 6'd1;
          if (idx_q == total_q - 6'd1) begin
            start_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.done) begin
          start_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous abort of any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      total_q   <= 6'd0;
      aout_q    <= '0;
      start_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      total_q   <= total_d;
      aout_q    <= aout_d;
      start_q   <= start_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.Aout      = aout_q;
  assign bus.start     = start_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: directed scenarios plus random frames,
// checked every cycle against a frame-level behavioural model.
module tb_matrix_stream_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_stream_loader_if bus ();

  matrix_stream_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Elements the driver intends to load into the current frame, in order.
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting elements, 2 waiting for done, 3 waiting for done release
  int          m_phase;
  int          m_cnt;
  int          m_total;
  logic [31:0] m_slots[36];
  logic        m_start;
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_total = 0; m_start = 0; m_err = 0;
      for (int k = 0; k < 36; k++) m_slots[k] = 32'h0;
    end else begin
      m_err = 0;
      if (m_phase == 0) begin
        if (bus.cfg_valid) begin
          if (bus.rows >= 1 && bus.rows <= 6 && bus.cols >= 1 && bus.cols <= 6) begin
            m_total = int'(bus.rows) * int'(bus.cols);
            for (int k = 0; k < 36; k++) m_slots[k] = 32'h0;
            m_cnt   = 0;
            m_phase = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.in_valid) begin
          m_slots[m_cnt] = bus.in_data;
          m_cnt++;
          if (m_cnt == m_total) begin
            m_start = 1;
            m_phase = 2;
          end
        end
      end else if (m_phase == 2) begin
        if (bus.done) begin
          m_start = 0;
          m_phase = 3;
        end
      end else begin
        if (!bus.done) m_phase = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking && !rst) begin
      int bad;
      bad = -1;
      check("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
      check("busy",     32'(bus.busy),     32'(m_phase != 0));
      check("start",    32'(bus.start),    32'(m_start));
      check("cfg_err",  32'(bus.cfg_err),  32'(m_err));
      for (int k = 35; k >= 0; k--)
        if (bus.Aout[k*32 +: 32] !== m_slots[k]) bad = k;
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL aout slot %0d: got %h, expected %h at %0t",
                 bad, bus.Aout[bad*32 +: 32], m_slots[bad], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_cfg(input logic [2:0] r, input logic [2:0] c);
    bus.cfg_valid = 1'b1;
    bus.rows      = r;
    bus.cols      = c;
    tick();
    bus.cfg_valid = 1'b0;
    bus.rows      = 3'($urandom);
    bus.cols      = 3'($urandom);
  endtask

  // Offers exp_q[first .. first+n-1]; returns cycles spent.
  task automatic send(input int first, input int n, input bit gaps, output int ticks);
    int  i;
    bit  v;
    bit  acc;
    i = first;
    ticks = 0;
    while (i < first + n && ticks < 500) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? exp_q[i] : $urandom;
      acc = v && bus.in_ready;
      tick();
      ticks++;
      if (acc) i++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    if (i != first + n) check("send_timeout", 32'(i), 32'(first + n));
  endtask

  task automatic wait_start;
    int t;
    t = 0;
    while (!bus.start && t < 100) begin
      tick();
      t++;
    end
    check("start_timeout", 32'(bus.start), 32'd1);
  endtask

  // Frame-level scoreboard: loaded elements in row-major slots, zeros above.
  task automatic check_frame;
    for (int k = 0; k < 36; k++)
      check($sformatf("frame_slot%0d", k), bus.Aout[k*32 +: 32],
            (k < exp_q.size()) ? exp_q[k] : 32'h0);
    exp_q.delete();
  endtask

  task automatic finish_frame(input int hold);
    repeat (hold) tick();
    bus.done = 1'b1;
    tick();
    check("start_after_done", 32'(bus.start), 32'd0);
    bus.done = 1'b0;
    tick();
    check("busy_after_release", 32'(bus.busy), 32'd0);
  endtask

  task automatic run_frame(input logic [2:0] r, input logic [2:0] c, input bit gaps, input int hold);
    int t;
    exp_q.delete();
    for (int k = 0; k < int'(r) * int'(c); k++) exp_q.push_back($urandom);
    do_cfg(r, c);
    send(0, int'(r) * int'(c), gaps, t);
    wait_start();
    check_frame();
    finish_frame(hold);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [2:0] bad_r[3];
    logic [2:0] bad_c[3];
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.rows = 3'd0; bus.cols = 3'd0;
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.done = 1'b0;
    #12;
    check("rst_start",    32'(bus.start),    32'd0);
    check("rst_cfg_err",  32'(bus.cfg_err),  32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_aout0",    bus.Aout[31:0],    32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    checking = 1'b1;
    tick();

    // Basic 2x3 frame, in_valid held high: 1.0 .. 6.0
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(32'h1000 * (k + 1));
    do_cfg(3'd2, 3'd3);
    check("basic_ready_after_cfg", 32'(bus.in_ready), 32'd1);
    send(0, 6, 1'b0, t);
    check("basic_accept_cycles", 32'(t), 32'd6);
    check("basic_start",         32'(bus.start),    32'd1);
    check("basic_ready_low",     32'(bus.in_ready), 32'd0);
    check("basic_slot0", bus.Aout[0 +: 32],   32'h00001000);
    check("basic_slot5", bus.Aout[160 +: 32], 32'h00006000);
    check("basic_slot6", bus.Aout[192 +: 32], 32'h00000000);
    check_frame();
    finish_frame(2);

    // Backpressure on 3x2, with junk offered while idle and while holding
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back($urandom);
    do_cfg(3'd3, 3'd2);
    send(0, 6, 1'b1, t);
    wait_start();
    bus.in_valid = 1'b1; bus.in_data = 32'hBAD0_0BAD;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check_frame();
    finish_frame(1);

    // Illegal dimensions
    bad_r[0] = 3'd0; bad_c[0] = 3'd3;
    bad_r[1] = 3'd7; bad_c[1] = 3'd2;
    bad_r[2] = 3'd3; bad_c[2] = 3'd7;
    for (int n = 0; n < 3; n++) begin
      do_cfg(bad_r[n], bad_c[n]);
      check("illegal_err",   32'(bus.cfg_err),  32'd1);
      check("illegal_ready", 32'(bus.in_ready), 32'd0);
      check("illegal_busy",  32'(bus.busy),     32'd0);
      tick();
      check("illegal_err_pulse", 32'(bus.cfg_err), 32'd0);
    end

    // Handshake hold on 6x6 with -1.0 in slot 35; done pulse in idle ignored
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 35; k++) exp_q.push_back($urandom);
    exp_q.push_back(32'hFFFF_F000);
    do_cfg(3'd6, 3'd6);
    send(0, 36, 1'b0, t);
    check("hs_slot35", bus.Aout[35*32 +: 32], 32'hFFFF_F000);
    check_frame();
    repeat (10) tick();
    check("hs_start_held", 32'(bus.start), 32'd1);
    finish_frame(0);

    // Reset mid-load after 4 of 9 accepts
    exp_q.delete();
    for (int k = 0; k < 9; k++) exp_q.push_back($urandom);
    do_cfg(3'd3, 3'd3);
    send(0, 4, 1'b0, t);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_start", 32'(bus.start),    32'd0);
    check("mid_rst_aout0", bus.Aout[31:0],    32'd0);
    check("mid_rst_aout3", bus.Aout[96 +: 32], 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_frame(3'd3, 3'd3, 1'b0, 1);

    // Stale data clearing: 6x6 then 1x1
    run_frame(3'd6, 3'd6, 1'b1, 0);
    exp_q.delete();
    exp_q.push_back(32'h7FFF_FFFF);
    do_cfg(3'd1, 3'd1);
    send(0, 1, 1'b0, t);
    check("stale_start", 32'(bus.start), 32'd1);
    check("stale_slot0", bus.Aout[31:0],  32'h7FFF_FFFF);
    check("stale_slot1", bus.Aout[63:32], 32'h0);
    check_frame();
    finish_frame(1);

    // Random frames, some with illegal dimensions
    for (int f = 0; f < 8; f++) begin
      logic [2:0] r;
      logic [2:0] c;
      r = 3'($urandom_range(0, 7));
      c = 3'($urandom_range(0, 7));
      if (r == 0 || r == 7 || c == 0 || c == 7) begin
        do_cfg(r, c);
        tick();
      end else begin
        run_frame(r, c, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
      end
    end

    repeat (3) tick();
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
